// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI command/register bridge.
package spi_reg_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CMD_RW_BIT = 7;
  localparam logic        CMD_READ   = 1'b1;

  localparam logic [BYTE_W-1:0] STATUS_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CMD      = 3'd1,
    S_WR       = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_CAPT  = 3'd4,
    S_RD       = 3'd5
  } state_e;

endpackage

// File: rtl/spi_reg_bridge.sv
// Turns SPI slave bytes into register-bus accesses with address auto-increment
// and supplies the next transmit byte back to the SPI slave.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 7,
  parameter logic [BYTE_W-1:0] STATUS_BYTE = STATUS_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_tsx_start,
  input  logic [BYTE_W-1:0] spi_data_out,
  input  logic              spi_data_stb,
  output logic [BYTE_W-1:0] spi_data_in,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [BYTE_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [BYTE_W-1:0] reg_rdata,
  output logic              busy
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [BYTE_W-1:0]   tx_q, tx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic                busy_q, busy_d;

  // State, address counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      tx_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tx_q    <= tx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; reg_re is raised on entry to RD_ISSUE so it is high
  // for exactly the RD_ISSUE cycle and read data lands during RD_CAPT.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tx_d    = tx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    busy_d  = busy_q;

    if (spi_tsx_start) begin
      // New frame from any state; a coincident byte strobe is dropped.
      state_d = S_CMD;
      tx_d    = STATUS_BYTE;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
        end
        S_CMD: begin
          if (spi_data_stb) begin
            ptr_d = spi_data_out[ADDR_W-1:0];
            if (spi_data_out[CMD_RW_BIT] == CMD_READ) begin
              re_d    = 1'b1;
              addr_d  = spi_data_out[ADDR_W-1:0];
              state_d = S_RD_ISSUE;
            end else begin
              state_d = S_WR;
            end
          end
        end
        S_WR: begin
          if (spi_data_stb) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = spi_data_out;
            ptr_d   = ptr_q + ADDR_W'(1);
          end
        end
        S_RD_ISSUE: begin
          state_d = S_RD_CAPT;
        end
        S_RD_CAPT: begin
          tx_d    = reg_rdata;
          ptr_d   = ptr_q + ADDR_W'(1);
          state_d = S_RD;
        end
        S_RD: begin
          if (spi_data_stb) begin
            re_d    = 1'b1;
            addr_d  = ptr_q;
            state_d = S_RD_ISSUE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign spi_data_in = tx_q;
  assign reg_addr    = addr_q;
  assign reg_wdata   = wdata_q;
  assign reg_we      = we_q;
  assign reg_re      = re_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: a host drives byte frames, a
// register file answers reads, and a frame-level model predicts accesses
// and the bytes the host receives.
module tb_spi_reg_bridge;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned GAP    = 12;
  localparam logic [7:0]  STATUS = 8'hA5;

  logic              clk = 1'b0;
  logic              rst;
  logic              spi_tsx_start;
  logic [7:0]        spi_data_out;
  logic              spi_data_stb;
  logic [7:0]        spi_data_in;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic              reg_re;
  logic [7:0]        reg_rdata;
  logic              busy;

  int total = 0;
  int bad   = 0;
  int mutex_err = 0;

  bit   [7:0]  mem     [128];
  bit   [7:0]  ref_mem [128];
  logic [15:0] acc_q[$];
  logic [15:0] exp_acc[$];
  logic [7:0]  host_rx_q[$];
  logic [7:0]  exp_rx[$];
  logic [7:0]  frame_q[$];

  spi_reg_bridge #(.ADDR_W(ADDR_W), .STATUS_BYTE(STATUS)) dut (
    .clk           (clk),
    .rst           (rst),
    .spi_tsx_start (spi_tsx_start),
    .spi_data_out  (spi_data_out),
    .spi_data_stb  (spi_data_stb),
    .spi_data_in   (spi_data_in),
    .reg_addr      (reg_addr),
    .reg_wdata     (reg_wdata),
    .reg_we        (reg_we),
    .reg_re        (reg_re),
    .reg_rdata     (reg_rdata),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Register file: read data valid exactly one clock after reg_re, garbage otherwise.
  always @(posedge clk) begin
    if (reg_we) mem[reg_addr] <= reg_wdata;
    reg_rdata <= reg_re ? mem[reg_addr] : 8'($urandom);
  end

  // Access monitor: one entry per strobe cycle {we, addr, wdata-or-0}.
  always @(negedge clk) begin
    if (reg_we) acc_q.push_back({1'b1, reg_addr, reg_wdata});
    if (reg_re) acc_q.push_back({1'b0, reg_addr, 8'h00});
    if (reg_we && reg_re) mutex_err++;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    spi_tsx_start = 1'b1;
    wait_cycles(1);
    spi_tsx_start = 1'b0;
    wait_cycles(4);
  endtask

  // The byte the slave transmits in this slot is whatever spi_data_in holds now.
  task automatic send_byte(input logic [7:0] b);
    host_rx_q.push_back(spi_data_in);
    spi_data_out = b;
    spi_data_stb = 1'b1;
    wait_cycles(1);
    spi_data_stb = 1'b0;
    spi_data_out = 8'($urandom);
    wait_cycles(GAP);
  endtask

  task automatic run_frame();
    acc_q.delete();
    host_rx_q.delete();
    start_frame();
    foreach (frame_q[i]) send_byte(frame_q[i]);
    wait_cycles(GAP);
  endtask

  // Frame-level model: command byte, then data (write) or dummy (read) bytes.
  task automatic model_frame();
    int base;
    int n;
    exp_acc.delete();
    exp_rx.delete();
    base = int'(frame_q[0][6:0]);
    n    = frame_q.size() - 1;
    exp_rx.push_back(STATUS);
    if (frame_q[0][7]) begin
      for (int i = 0; i < n; i++) begin
        exp_acc.push_back({1'b0, 7'((base + i) % 128), 8'h00});
        exp_rx.push_back(ref_mem[(base + i) % 128]);
      end
      exp_acc.push_back({1'b0, 7'((base + n) % 128), 8'h00});
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_acc.push_back({1'b1, 7'((base + i) % 128), frame_q[i+1]});
        ref_mem[(base + i) % 128] = frame_q[i+1];
        exp_rx.push_back(STATUS);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; spi_tsx_start = 1'b0; spi_data_stb = 1'b0; spi_data_out = 8'h00;
    wait_cycles(3);
    total++;
    if ({reg_we, reg_re, reg_addr, reg_wdata, spi_data_in, busy} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got we=%b re=%b addr=%h wd=%h tx=%h busy=%b want all 0",
               reg_we, reg_re, reg_addr, reg_wdata, spi_data_in, busy);
    end
    rst = 1'b0;
    wait_cycles(2);
    acc_q.delete();
    host_rx_q.delete();
    send_byte(8'h85);
    total++;
    if (acc_q.size() != 0 || spi_data_in !== 8'h00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_strobe: got accesses=%0d tx=%h busy=%b want 0/00/0",
               acc_q.size(), spi_data_in, busy);
    end
  endtask

  task automatic test_write_frame();
    frame_q = '{8'h10, 8'hDE, 8'hAD};
    model_frame();
    run_frame();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL write_busy: got %b want 1", busy); end
    total++;
    if (acc_q.size() != exp_acc.size()) begin
      bad++; $display("FAIL write_count: got %0d want %0d", acc_q.size(), exp_acc.size());
    end
    foreach (exp_acc[i]) begin
      total++;
      if (i >= acc_q.size() || acc_q[i] !== exp_acc[i]) begin
        bad++; $display("FAIL write_acc[%0d]: got %h want %h", i, (i < acc_q.size()) ? acc_q[i] : 16'hxxxx, exp_acc[i]);
      end
    end
    foreach (exp_rx[i]) begin
      total++;
      if (host_rx_q[i] !== exp_rx[i]) begin
        bad++; $display("FAIL write_rx[%0d]: got %h want %h", i, host_rx_q[i], exp_rx[i]);
      end
    end
  endtask

  task automatic test_read_frame();
    frame_q = '{8'h20, 8'h11, 8'h22};
    model_frame();
    run_frame();
    frame_q = '{8'hA0, 8'h00, 8'h00};
    model_frame();
    run_frame();
    total++;
    if (acc_q.size() != exp_acc.size()) begin
      bad++; $display("FAIL read_count: got %0d want %0d", acc_q.size(), exp_acc.size());
    end
    foreach (exp_acc[i]) begin
      total++;
      if (i >= acc_q.size() || acc_q[i] !== exp_acc[i]) begin
        bad++; $display("FAIL read_acc[%0d]: got %h want %h", i, (i < acc_q.size()) ? acc_q[i] : 16'hxxxx, exp_acc[i]);
      end
    end
    foreach (exp_rx[i]) begin
      total++;
      if (host_rx_q[i] !== exp_rx[i]) begin
        bad++; $display("FAIL read_rx[%0d]: got %h want %h", i, host_rx_q[i], exp_rx[i]);
      end
    end
  endtask

  task automatic test_wrap();
    frame_q = '{8'h7F, 8'h01, 8'h02};
    model_frame();
    run_frame();
    total++;
    if (acc_q.size() != 2) begin
      bad++; $display("FAIL wrap_count: got %0d want 2", acc_q.size());
    end
    foreach (exp_acc[i]) begin
      total++;
      if (i >= acc_q.size() || acc_q[i] !== exp_acc[i]) begin
        bad++; $display("FAIL wrap_acc[%0d]: got %h want %h", i, (i < acc_q.size()) ? acc_q[i] : 16'hxxxx, exp_acc[i]);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 10; f++) begin
      frame_q.delete();
      frame_q.push_back(8'($urandom));
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) frame_q.push_back(8'($urandom));
      model_frame();
      run_frame();
      total++;
      if (acc_q.size() != exp_acc.size()) begin
        bad++; $display("FAIL rand%0d_count: got %0d want %0d", f, acc_q.size(), exp_acc.size());
      end
      foreach (exp_acc[i]) begin
        total++;
        if (i >= acc_q.size() || acc_q[i] !== exp_acc[i]) begin
          bad++; $display("FAIL rand%0d_acc[%0d]: got %h want %h", f, i, (i < acc_q.size()) ? acc_q[i] : 16'hxxxx, exp_acc[i]);
        end
      end
      foreach (exp_rx[i]) begin
        total++;
        if (host_rx_q[i] !== exp_rx[i]) begin
          bad++; $display("FAIL rand%0d_rx[%0d]: got %h want %h", f, i, host_rx_q[i], exp_rx[i]);
        end
      end
    end
  endtask

  task automatic test_abort();
    // Write frame cut after one data byte; the next frame writes from its own command.
    acc_q.delete();
    start_frame();
    send_byte(8'h40);
    send_byte(8'h77);
    start_frame();
    send_byte(8'h41);
    send_byte(8'h88);
    wait_cycles(GAP);
    ref_mem[8'h40] = 8'h77;
    ref_mem[8'h41] = 8'h88;
    total++;
    if (acc_q.size() != 2 || acc_q[0] !== 16'hC077 || acc_q[1] !== 16'hC188) begin
      bad++; $display("FAIL abort_write: got n=%0d %h %h want 2 c077 c188",
                      acc_q.size(), acc_q.size() > 0 ? acc_q[0] : 16'hxxxx, acc_q.size() > 1 ? acc_q[1] : 16'hxxxx);
    end
    // Read frame cut while holding prefetched data; restart must reload the status byte.
    frame_q = '{8'h50, 8'hC3, 8'h3C};
    model_frame();
    run_frame();
    start_frame();
    send_byte(8'hD0);
    send_byte(8'h00);
    total++;
    if (spi_data_in !== 8'h3C) begin bad++; $display("FAIL abort_prefetch: got %h want 3c", spi_data_in); end
    start_frame();
    total++;
    if (spi_data_in !== STATUS || busy !== 1'b1) begin
      bad++; $display("FAIL abort_status: got tx=%h busy=%b want a5/1", spi_data_in, busy);
    end
  endtask

  task automatic test_collision();
    start_frame();
    send_byte(8'h30);
    acc_q.delete();
    spi_tsx_start = 1'b1;
    spi_data_stb  = 1'b1;
    spi_data_out  = 8'h99;
    wait_cycles(1);
    spi_tsx_start = 1'b0;
    spi_data_stb  = 1'b0;
    wait_cycles(GAP);
    total++;
    if (acc_q.size() != 0 || spi_data_in !== STATUS) begin
      bad++; $display("FAIL collision_drop: got accesses=%0d tx=%h want 0/a5", acc_q.size(), spi_data_in);
    end
    send_byte(8'h31);
    send_byte(8'h66);
    ref_mem[8'h31] = 8'h66;
    total++;
    if (acc_q.size() != 1 || acc_q[0] !== 16'hB166) begin
      bad++; $display("FAIL collision_cmd: got n=%0d %h want 1 b166",
                      acc_q.size(), acc_q.size() > 0 ? acc_q[0] : 16'hxxxx);
    end
  endtask

  task automatic test_reset_mid_read();
    start_frame();
    send_byte(8'hA0);
    send_byte(8'h00);
    rst = 1'b1;
    wait_cycles(1);
    total++;
    if ({reg_we, reg_re, reg_addr, reg_wdata, spi_data_in, busy} !== '0) begin
      bad++;
      $display("FAIL midread_reset: got we=%b re=%b addr=%h wd=%h tx=%h busy=%b want all 0",
               reg_we, reg_re, reg_addr, reg_wdata, spi_data_in, busy);
    end
    rst = 1'b0;
    wait_cycles(2);
    acc_q.delete();
    send_byte(8'h00);
    send_byte(8'h12);
    total++;
    if (acc_q.size() != 0 || spi_data_in !== 8'h00 || busy !== 1'b0) begin
      bad++; $display("FAIL midread_nostart: got accesses=%0d tx=%h busy=%b want 0/00/0",
                      acc_q.size(), spi_data_in, busy);
    end
  endtask

  initial begin
    test_reset();
    test_write_frame();
    test_read_frame();
    test_wrap();
    test_random_frames();
    test_abort();
    test_collision();
    test_reset_mid_read();
    total++;
    if (mutex_err !== 0) begin
      bad++; $display("FAIL strobe_mutex: got %0d overlaps want 0", mutex_err);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
